// File: rtl/systolic_array_top.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// systolic_array_top
//
// Output-stationary M x N multiply-accumulate array.  Two independent operand
// streams (A and B) are captured in one-entry holding registers; when both
// holds are full the pair is launched into the array.  Row r receives the
// launched A delayed r cycles, column c receives the launched B delayed c
// cycles, and every PE forwards its operands one hop east/south per cycle,
// so every PE accumulates the same product sequence.
//
// Ports:
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   a_in       : operand A data        a_in_valid / a_in_ready : A handshake
//   b_in       : operand B data        b_in_valid / b_in_ready : B handshake
// Results live in row[r].col[c].pe_inst.{acc_reg, out, out_valid}.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// systolic_pe
//
// One processing element.  Accumulates a_west*b_north whenever both incoming
// valids are high and forwards the operands with their valids one cycle later.
//
// Ports:
//   clk, rst_n                  : clock / synchronous active-low reset
//   a_west, a_valid_west        : operand A from the west neighbour
//   b_north, b_valid_north      : operand B from the north neighbour
//   a_east, a_valid_east        : registered A towards the east neighbour
//   b_south, b_valid_south      : registered B towards the south neighbour
//   out_ready                   : downstream accepts out
//   out, out_valid              : latest accumulator value and its strobe
// ---------------------------------------------------------------------------
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_west,
    input  logic              a_valid_west,
    input  logic [DATA_W-1:0] b_north,
    input  logic              b_valid_north,
    output logic [DATA_W-1:0] a_east,
    output logic              a_valid_east,
    output logic [DATA_W-1:0] b_south,
    output logic              b_valid_south,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out,
    output logic              out_valid
);

    logic [ACC_W-1:0]    acc_reg;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    acc_next;
    logic                in_valid;

    // Both operand valids travel in lock-step by construction.
    assign in_valid = a_valid_west && b_valid_north;

    // The low 2*DATA_W bits of the product of the extended operands equal the
    // true (signed or unsigned) product, which is then extended to ACC_W.
    if (SIGNED != 0) begin : g_signed
        assign a_ext    = {{DATA_W{a_west[DATA_W-1]}}, a_west};
        assign b_ext    = {{DATA_W{b_north[DATA_W-1]}}, b_north};
        assign prod     = a_ext * b_ext;
        assign prod_ext = ACC_W'($signed(prod));
    end else begin : g_unsigned
        assign a_ext    = {{DATA_W{1'b0}}, a_west};
        assign b_ext    = {{DATA_W{1'b0}}, b_north};
        assign prod     = a_ext * b_ext;
        assign prod_ext = ACC_W'(prod);
    end

    assign acc_next = acc_reg + prod_ext;   // wraps modulo 2^ACC_W

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            out           <= '0;
            out_valid     <= 1'b0;
            a_east        <= '0;
            a_valid_east  <= 1'b0;
            b_south       <= '0;
            b_valid_south <= 1'b0;
        end else begin
            a_east        <= a_west;
            a_valid_east  <= a_valid_west;
            b_south       <= b_north;
            b_valid_south <= b_valid_north;
            if (in_valid) begin
                acc_reg <= acc_next;
                out     <= acc_next;
            end
            // A result not yet taken downstream stays valid; with out_ready
            // tied high this is a one-cycle strobe per update.
            out_valid <= in_valid || (out_valid && !out_ready);
        end
    end

endmodule

module systolic_array_top #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int M      = 4,
    parameter int N      = 4,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_in_valid,
    output logic              a_in_ready,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_in_valid,
    output logic              b_in_ready
);

    // ---------------- input stage ----------------
    logic [DATA_W-1:0] hold_a_reg;
    logic [DATA_W-1:0] hold_b_reg;
    logic              hold_a_full_reg;
    logic              hold_b_full_reg;
    logic              run_reg;       // low for the cycle right after reset
    logic              launch;
    logic              a_accept;
    logic              b_accept;

    assign launch     = hold_a_full_reg && hold_b_full_reg;
    assign a_in_ready = rst_n && run_reg && (!hold_a_full_reg || launch);
    assign b_in_ready = rst_n && run_reg && (!hold_b_full_reg || launch);
    assign a_accept   = a_in_valid && a_in_ready;
    assign b_accept   = b_in_valid && b_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_reg         <= 1'b0;
            hold_a_reg      <= '0;
            hold_b_reg      <= '0;
            hold_a_full_reg <= 1'b0;
            hold_b_full_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            // A new accept in the launch cycle refills the hold immediately.
            if (a_accept) begin
                hold_a_reg      <= a_in;
                hold_a_full_reg <= 1'b1;
            end else if (launch) begin
                hold_a_full_reg <= 1'b0;
            end
            if (b_accept) begin
                hold_b_reg      <= b_in;
                hold_b_full_reg <= 1'b1;
            end else if (launch) begin
                hold_b_full_reg <= 1'b0;
            end
        end
    end

    // ---------------- skew chains ----------------
    // west_a[r] is the launched A delayed r cycles; north_b[c] likewise for B.
    logic [DATA_W-1:0] west_a  [M];
    logic              west_v  [M];
    logic [DATA_W-1:0] north_b [N];
    logic              north_v [N];

    for (genvar gi = 0; gi < M; gi++) begin : g_skew_a
        if (gi == 0) begin : g_head
            assign west_a[gi] = hold_a_reg;
            assign west_v[gi] = launch;
        end else begin : g_dly
            logic [DATA_W-1:0] d_reg;
            logic              v_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    d_reg <= '0;
                    v_reg <= 1'b0;
                end else begin
                    d_reg <= west_a[gi-1];
                    v_reg <= west_v[gi-1];
                end
            end
            assign west_a[gi] = d_reg;
            assign west_v[gi] = v_reg;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_skew_b
        if (gi == 0) begin : g_head
            assign north_b[gi] = hold_b_reg;
            assign north_v[gi] = launch;
        end else begin : g_dly
            logic [DATA_W-1:0] d_reg;
            logic              v_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    d_reg <= '0;
                    v_reg <= 1'b0;
                end else begin
                    d_reg <= north_b[gi-1];
                    v_reg <= north_v[gi-1];
                end
            end
            assign north_b[gi] = d_reg;
            assign north_v[gi] = v_reg;
        end
    end

    // ---------------- PE grid ----------------
    // a_h/av_h run west->east (column index N is the east edge);
    // b_v/bv_v run north->south (row index M is the south edge).
    logic [DATA_W-1:0] a_h  [M][N+1];
    logic              av_h [M][N+1];
    logic [DATA_W-1:0] b_v  [M+1][N];
    logic              bv_v [M+1][N];
    logic [M*N-1:0]    out_ready;

    assign out_ready = '1;

    for (genvar gi = 0; gi < M; gi++) begin : g_west
        assign a_h[gi][0]  = west_a[gi];
        assign av_h[gi][0] = west_v[gi];
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_north
        assign b_v[0][gi]  = north_b[gi];
        assign bv_v[0][gi] = north_v[gi];
    end

    for (genvar r = 0; r < M; r++) begin : row
        for (genvar c = 0; c < N; c++) begin : col
            logic [ACC_W-1:0] pe_out;
            logic             pe_out_valid;
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) pe_inst (
                .clk           (clk),
                .rst_n         (rst_n),
                .a_west        (a_h[r][c]),
                .a_valid_west  (av_h[r][c]),
                .b_north       (b_v[r][c]),
                .b_valid_north (bv_v[r][c]),
                .a_east        (a_h[r][c+1]),
                .a_valid_east  (av_h[r][c+1]),
                .b_south       (b_v[r+1][c]),
                .b_valid_south (bv_v[r+1][c]),
                .out_ready     (out_ready[r*N+c]),
                .out           (pe_out),
                .out_valid     (pe_out_valid)
            );
        end
    end

endmodule

// File: tb/tb_systolic_array_top.sv
`timescale 1ns/1ps
module tb_systolic_array_top;

    localparam int M   = 4;
    localparam int N   = 4;
    localparam int NPE = M * N;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       a_in_valid = 1'b0;
    logic       b_in_valid = 1'b0;
    logic       a_rdy_u, b_rdy_u, a_rdy_s, b_rdy_s, a_rdy_w, b_rdy_w;

    always #5 clk = ~clk;

    // Three configurations share one stimulus: unsigned/32, signed/32, unsigned/16.
    systolic_array_top #(.DATA_W(8), .ACC_W(32), .M(M), .N(N), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n),
        .a_in(a_in), .a_in_valid(a_in_valid), .a_in_ready(a_rdy_u),
        .b_in(b_in), .b_in_valid(b_in_valid), .b_in_ready(b_rdy_u));
    systolic_array_top #(.DATA_W(8), .ACC_W(32), .M(M), .N(N), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .a_in(a_in), .a_in_valid(a_in_valid), .a_in_ready(a_rdy_s),
        .b_in(b_in), .b_in_valid(b_in_valid), .b_in_ready(b_rdy_s));
    systolic_array_top #(.DATA_W(8), .ACC_W(16), .M(M), .N(N), .SIGNED(0)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .a_in(a_in), .a_in_valid(a_in_valid), .a_in_ready(a_rdy_w),
        .b_in(b_in), .b_in_valid(b_in_valid), .b_in_ready(b_rdy_w));

    logic [31:0] acc_u [NPE];
    logic [31:0] acc_s [NPE];
    logic [15:0] acc_w [NPE];

    for (genvar gi = 0; gi < M; gi++) begin : g_r
        for (genvar gj = 0; gj < N; gj++) begin : g_c
            assign acc_u[gi*N+gj] = dut_u.row[gi].col[gj].pe_inst.acc_reg;
            assign acc_s[gi*N+gj] = dut_s.row[gi].col[gj].pe_inst.acc_reg;
            assign acc_w[gi*N+gj] = dut_w.row[gi].col[gj].pe_inst.acc_reg;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Accepted operands are queued per stream; pairs form in arrival order.
    // A pair completed at edge k shows up at PE[0][0] after edge k+1 and at
    // PE[M-1][N-1] after edge k+1+(M-1)+(N-1).
    typedef struct {
        logic [31:0] val;
        int          stamp;
    } exp_t;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    exp_t        q00[$];
    exp_t        qlast[$];
    logic [31:0] sum_u = '0;
    logic [31:0] sum_s = '0;
    logic [15:0] sum_w = '0;
    int          cyc = 0;
    int          pair_cnt = 0;
    int          max_hold = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst_n) begin
                qa.delete(); qb.delete(); q00.delete(); qlast.delete();
                sum_u = '0; sum_s = '0; sum_w = '0;
            end else begin
                if (a_in_valid && a_rdy_u) qa.push_back(a_in);
                if (b_in_valid && b_rdy_u) qb.push_back(b_in);
                if (qa.size() > 0 && qb.size() > 0) begin
                    logic [7:0] a, b;
                    int sa, sb;
                    exp_t e;
                    a = qa.pop_front();
                    b = qb.pop_front();
                    sa = int'($signed(a));
                    sb = int'($signed(b));
                    sum_u = sum_u + 32'(a) * 32'(b);
                    sum_s = sum_s + 32'(sa * sb);
                    sum_w = sum_w + 16'(32'(a) * 32'(b));
                    pair_cnt++;
                    e.val = sum_u; e.stamp = cyc + 1;
                    q00.push_back(e);
                    e.stamp = cyc + 1 + (M - 1) + (N - 1);
                    qlast.push_back(e);
                    $display("pair %0d @cyc %0d: a=%0d b=%0d acc_u=%0d acc_s=%0d acc_w=%0d",
                             pair_cnt, cyc, a, b, sum_u, $signed(sum_s), sum_w);
                end
                if (qa.size() > max_hold) max_hold = qa.size();
                if (qb.size() > max_hold) max_hold = qb.size();
            end
        end
    end

    // Output monitor: values and timing of PE[0][0] and PE[M-1][N-1].
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("ready_a_agree", {31'b0, a_rdy_s & a_rdy_w}, {31'b0, a_rdy_u});
                if (dut_u.row[0].col[0].pe_inst.out_valid) begin
                    if (q00.size() == 0) begin
                        check("pe00_unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q00.pop_front();
                        check("pe00_out", dut_u.row[0].col[0].pe_inst.out, e.val);
                        check("pe00_cycle", 32'(cyc), 32'(e.stamp));
                    end
                end
                if (dut_u.row[M-1].col[N-1].pe_inst.out_valid) begin
                    if (qlast.size() == 0) begin
                        check("pe33_unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = qlast.pop_front();
                        check("pe33_out", dut_u.row[M-1].col[N-1].pe_inst.out, e.val);
                        check("pe33_cycle", 32'(cyc), 32'(e.stamp));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        bit ad = 0, bd = 0, wa, wb;
        int guard = 0;
        a_in = a; b_in = b; a_in_valid = 1'b1; b_in_valid = 1'b1;
        while (!(ad && bd)) begin
            @(negedge clk);
            wa = a_in_valid && a_rdy_u;
            wb = b_in_valid && b_rdy_u;
            @(posedge clk); #1;
            if (wa) begin ad = 1; a_in_valid = 1'b0; end
            if (wb) begin bd = 1; b_in_valid = 1'b0; end
            guard++;
            if (guard > 50) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: pair a=%0d b=%0d not accepted within 50 cycles", a, b);
                a_in_valid = 1'b0; b_in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic drain();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic check_acc(input string tag, input logic [31:0] eu,
                             input logic [31:0] es, input logic [15:0] ew);
        for (int i = 0; i < NPE; i++) begin
            check($sformatf("%s_u_pe%0d", tag, i), acc_u[i], eu);
            check($sformatf("%s_s_pe%0d", tag, i), acc_s[i], es);
            check($sformatf("%s_w_pe%0d", tag, i), {16'b0, acc_w[i]}, {16'b0, ew});
        end
        check($sformatf("%s_outs_drained", tag), 32'(q00.size() + qlast.size()), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          first;   // reset before this entry, starting a new group
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] exp_u;   // running totals after this pair
        logic [31:0] exp_s;
        logic [15:0] exp_w;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int t0;
        int grp_pairs;

        tbl[0] = '{1'b1, 8'd2,   8'd3,   32'd6,      32'd6,          16'd6};
        tbl[1] = '{1'b0, 8'd3,   8'd4,   32'd18,     32'd18,         16'd18};
        tbl[2] = '{1'b0, 8'd4,   8'd5,   32'd38,     32'd38,         16'd38};
        tbl[3] = '{1'b0, 8'd5,   8'd6,   32'd68,     32'd68,         16'd68};
        tbl[4] = '{1'b0, 8'd6,   8'd7,   32'd110,    32'd110,        16'd110};
        tbl[5] = '{1'b1, 8'hFE,  8'd3,   32'd762,    32'hFFFF_FFFA,  16'd762};
        tbl[6] = '{1'b0, 8'hFF,  8'hFF,  32'd65787,  32'hFFFF_FFFB,  16'd251};
        tbl[7] = '{1'b1, 8'd255, 8'd255, 32'd65025,  32'd1,          16'd65025};
        tbl[8] = '{1'b0, 8'd255, 8'd255, 32'd130050, 32'd2,          16'd64514};

        // Reset state and release timing.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a_ready", {31'b0, a_rdy_u}, 32'd0);
        check("reset_b_ready", {31'b0, b_rdy_u}, 32'd0);
        check("reset_out_valid", {31'b0, dut_u.row[0].col[0].pe_inst.out_valid}, 32'd0);
        for (int i = 0; i < NPE; i++) check($sformatf("reset_acc_pe%0d", i), acc_u[i], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_ready_still_low", {31'b0, a_rdy_u}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("release_ready_high", {31'b0, a_rdy_u & b_rdy_u}, 32'd1);

        // Table groups: back-to-back pairs, checked against the table totals.
        t0 = 0; grp_pairs = 0;
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].first) begin
                do_reset();
                t0 = cyc; grp_pairs = 0;
            end
            send_pair(tbl[i].a, tbl[i].b);
            grp_pairs++;
            if (i == 8 || tbl[(i + 1) % 9].first) begin
                check($sformatf("grp%0d_throughput_cycles", i), 32'(cyc - t0), 32'(grp_pairs));
                drain();
                check_acc($sformatf("tbl%0d", i), tbl[i].exp_u, tbl[i].exp_s, tbl[i].exp_w);
            end
        end

        // Unbalanced streams: A alone for three cycles, then B.
        do_reset();
        a_in = 8'd5; a_in_valid = 1'b1;
        @(negedge clk);
        check("unbal_a_ready_first", {31'b0, a_rdy_u}, 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("unbal_a_ready_blocked%0d", k), {31'b0, a_rdy_u}, 32'd0);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        b_in = 8'd4; b_in_valid = 1'b1;
        @(negedge clk);
        check("unbal_b_ready", {31'b0, b_rdy_u}, 32'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        drain();
        check_acc("unbal", 32'd20, 32'd20, 16'd20);

        // Reset in the middle of a stream.
        do_reset();
        a_in_valid = 1'b1; b_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_in = 8'(k + 1); b_in = 8'(k + 2);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_a_ready", {31'b0, a_rdy_u}, 32'd0);
        check("midrst_b_ready", {31'b0, b_rdy_u}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < NPE; i++) check($sformatf("midrst_acc_pe%0d", i), acc_u[i], 32'd0);
        rst_n = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
        @(negedge clk);
        check("midrst_ready_after_release", {31'b0, a_rdy_u}, 32'd0);
        @(posedge clk); #1;
        send_pair(8'd7, 8'd9);
        send_pair(8'd1, 8'd1);
        send_pair(8'd10, 8'd10);
        drain();
        check_acc("midrst", 32'd164, 32'd164, 16'd164);

        // Random independent streams against the reference model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            a_in_valid = 1'($urandom_range(0, 1));
            b_in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        drain();
        check_acc("random", sum_u, sum_s, sum_w);
        check("random_hold_depth", 32'(max_hold), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
